hilo_md_ctrl: RTL

Iterative multiply/divide sequencer for the HI/LO register pair. It sits beside the EX stage and accepts MULT/MULTU/DIV/DIVU operands from EX. It computes the 64-bit result one bit per cycle and holds the pipeline through `stallreq` while it works. It then delivers a single-cycle write on a 66-bit bus in the same `{hi_we, lo_we, hi, lo}` format consumed by the HI/LO register and its forwarding logic.

---
 rtl/hilo_md_ctrl_if.sv | 22 ++
 rtl/hilo_md_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl_if.sv
// EX-side bundle for the HI/LO multiply/divide sequencer.
// start is a level request held by EX until stallreq drops; hilo_bus carries a one-cycle write when its enables are high.
interface hilo_md_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        busy;
    logic [65:0] hilo_bus;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stallreq, busy, hilo_bus
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stallreq, busy, hilo_bus
    );
endinterface

// File: rtl/hilo_md_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer producing a one-bit-per-cycle result for HI/LO.
// State is exported on dbg_state: 0 IDLE, 1 CALC, 2 DONE.
module hilo_md_ctrl #(
    parameter int ITER = 32
) (
    input  logic         clk,
    input  logic         rst,
    hilo_md_ctrl_if.slave md,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    op_q;
    logic [31:0]   opa_q;
    logic [31:0]   opb_q;
    logic [31:0]   src_a_q;
    logic          sign_q;
    logic          rsign_q;
    logic          dz_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   acc_q;
    logic [31:0]   rem_q;

    logic        accept;
    logic        signed_in;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        is_div;
    logic        signed_q;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [63:0] prod;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    assign accept    = (state == IDLE) && md.start && !md.cancel;
    assign signed_in = ~md.op[0];
    assign abs_a     = (signed_in && md.src_a[31]) ? -md.src_a : md.src_a;
    assign abs_b     = (signed_in && md.src_b[31]) ? -md.src_b : md.src_b;
    assign is_div    = op_q[1];
    assign signed_q  = ~op_q[0];

    // Multiply: opa_q is the multiplicand, opb_q the multiplier shifted out LSB-first.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);

    // Divide: opa_q holds the dividend and collects quotient bits as it shifts left.
    assign div_shift = {rem_q, opa_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ok    = ~div_diff[32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (md.cancel) begin
                    state_nxt = IDLE;
                end else if (cnt_q == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= 2'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            src_a_q <= 32'd0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
        end else if (accept) begin
            op_q    <= md.op;
            opa_q   <= abs_a;
            opb_q   <= abs_b;
            src_a_q <= md.src_a;
            sign_q  <= md.src_a[31] ^ md.src_b[31];
            rsign_q <= md.src_a[31];
            dz_q    <= (md.src_b == 32'd0);
            cnt_q   <= '0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
        end else if (state == CALC) begin
            cnt_q <= cnt_q + CW'(1);
            if (is_div) begin
                rem_q <= div_ok ? div_diff[31:0] : div_shift[31:0];
                opa_q <= {opa_q[30:0], div_ok};
            end else begin
                acc_q <= {mul_sum, acc_q[31:1]};
                opb_q <= {1'b0, opb_q[31:1]};
            end
        end
    end

    // Sign fixup; the |0x80000000| wrap makes DIV 0x80000000/-1 land on 0x80000000 naturally.
    always_comb begin
        prod   = (signed_q && sign_q) ? -acc_q : acc_q;
        hi_res = prod[63:32];
        lo_res = prod[31:0];
        if (is_div) begin
            if (dz_q) begin
                hi_res = src_a_q;
                lo_res = 32'hFFFF_FFFF;
            end else begin
                hi_res = (signed_q && rsign_q) ? -rem_q : rem_q;
                lo_res = (signed_q && sign_q)  ? -opa_q : opa_q;
            end
        end
    end

    assign md.stallreq = rst && (accept || (state == CALC));
    assign md.busy     = (state == CALC) || (state == DONE);
    assign md.hilo_bus = (state == DONE) ? {~md.cancel, ~md.cancel, hi_res, lo_res} : 66'd0;
    assign dbg_state   = state;

endmodule
